// File: rtl/vector_store_serializer_if.sv
// Bus bundle for vector_store_serializer: the memory-stage store request,
// the data-memory write port and the stall/done status back to the pipeline.
// Optional LaneMaskM signal is present only when VSTORE_MASK_EN is defined.
// Handshake: a memory write is transferred on a rising edge where
// MemWE && MemReady; while MemWE=1 and MemReady=0 the address and data
// stay stable. StartM is a level request that is only taken while BusyM=0.
interface vector_store_serializer_if #(
    parameter int N  = 8,
    parameter int AW = 32
);
    logic                StartM;
    logic                ScalarM;
    logic [5:0][N-1:0]   VecDataM;
    logic [AW-1:0]       BaseAddrM;
`ifdef VSTORE_MASK_EN
    logic [5:0]          LaneMaskM;
`endif
    logic                MemReady;
    logic                MemWE;
    logic [AW-1:0]       MemAddr;
    logic [N-1:0]        MemWD;
    logic                BusyM;
    logic                DoneM;

    // Pipeline / memory side (drives requests and ready, observes writes)
    modport master (
`ifdef VSTORE_MASK_EN
        output LaneMaskM,
`endif
        output StartM, ScalarM, VecDataM, BaseAddrM, MemReady,
        input  MemWE, MemAddr, MemWD, BusyM, DoneM
    );

    // Serializer side
    modport slave (
`ifdef VSTORE_MASK_EN
        input  LaneMaskM,
`endif
        input  StartM, ScalarM, VecDataM, BaseAddrM, MemReady,
        output MemWE, MemAddr, MemWD, BusyM, DoneM
    );
endinterface

// File: rtl/vector_store_serializer.sv
// vector_store_serializer: writes a captured 6-lane vector to data memory one
// lane per accepted write (lane i to base+i), stalling the pipeline with BusyM.
// Scalar stores write lane 0 only. Optional per-lane masking is enabled by
// defining VSTORE_MASK_EN; masked-off lanes are skipped without costing cycles.
// All outputs are decoded from registered state; no input-to-output path.
module vector_store_serializer #(
    parameter int N  = 8,
    parameter int AW = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    vector_store_serializer_if.slave  bus,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [5:0][N-1:0]   r_data;
    logic [AW-1:0]       r_base;
    logic [5:0]          r_mask;
    logic [2:0]          r_lane;

    logic [5:0]          w_em;
    logic [2:0]          w_first_lane;
    logic [2:0]          w_next_lane;
    logic                w_has_next;
    logic                w_start;
    logic                w_accept;

    assign w_start  = (r_state == S_IDLE) && bus.StartM;
    assign w_accept = (r_state == S_WRITE) && bus.MemReady;

    // Effective mask of the incoming request: scalar forces lane 0 only
    always_comb begin
        w_em = 6'b111111;
`ifdef VSTORE_MASK_EN
        w_em = bus.LaneMaskM;
`endif
        if (bus.ScalarM) begin
            w_em = 6'b000001;
        end
    end

    // Lowest enabled lane of the incoming request (descending scan, last hit wins)
    always_comb begin
        w_first_lane = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_em[i]) begin
                w_first_lane = 3'(i);
            end
        end
    end

    // Next enabled lane strictly above the current one, from the captured mask
    always_comb begin
        w_next_lane = 3'd0;
        w_has_next  = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) > r_lane)) begin
                w_next_lane = 3'(i);
                w_has_next  = 1'b1;
            end
        end
    end

    // Next-state logic; an empty mask skips straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.StartM) begin
                    w_next_state = (w_em != 6'd0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                if (bus.MemReady && !w_has_next) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any store in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and lane advance on each accepted write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_base <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (w_start) begin
            r_data <= bus.VecDataM;
            r_base <= bus.BaseAddrM;
            r_mask <= w_em;
            r_lane <= w_first_lane;
        end else if (w_accept && w_has_next) begin
            r_lane <= w_next_lane;
        end
    end

    assign bus.MemWE   = (r_state == S_WRITE);
    assign bus.MemAddr = r_base + AW'(r_lane);
    assign bus.MemWD   = r_data[r_lane];
    assign bus.BusyM   = (r_state != S_IDLE);
    assign bus.DoneM   = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Self-checking bench for vector_store_serializer. A transaction-level model
// turns each accepted request into a queue of expected (address, data) writes
// and checks the write port, BusyM and DoneM on every cycle. Directed cases
// pin the model with literal addresses, data and cycle numbers.
// Define VSTORE_MASK_EN to also exercise lane masking.
module tb_vector_store_serializer;
    localparam int N  = 8;
    localparam int AW = 32;
`ifdef VSTORE_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    vector_store_serializer_if #(.N(N), .AW(AW)) bus ();

    vector_store_serializer #(.N(N), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW+N-1:0] exp_q[$];
    bit              m_busy = 1'b0;
    logic [AW-1:0]   obs_addr[$];
    logic [N-1:0]    obs_data[$];
    int              obs_cyc[$];
    int              done_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (updated on each edge) ----------------
    always @(posedge clk) begin
        logic [5:0] em;
        if (bus.DoneM) done_log.push_back(cyc);
        if (bus.MemWE && bus.MemReady) begin
            obs_addr.push_back(bus.MemAddr);
            obs_data.push_back(bus.MemWD);
            obs_cyc.push_back(cyc);
        end
        if (rst) begin
            m_busy = 1'b0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (bus.StartM) begin
                em = 6'b111111;
`ifdef VSTORE_MASK_EN
                em = bus.LaneMaskM;
`endif
                if (bus.ScalarM) em = 6'b000001;
                for (int i = 0; i < 6; i++) begin
                    if (em[i]) exp_q.push_back({bus.BaseAddrM + AW'(i), bus.VecDataM[i]});
                end
                m_busy = 1'b1;
            end
        end else if (exp_q.size() > 0) begin
            if (bus.MemReady) void'(exp_q.pop_front());
        end else begin
            m_busy = 1'b0;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("busy", 64'(bus.BusyM), 64'(m_busy));
        check("dbg_state_idle", 64'(dbg_state == 2'd0), 64'(!m_busy));
        if (m_busy && exp_q.size() > 0) begin
            check("we", 64'(bus.MemWE), 64'd1);
            check("addr", 64'(bus.MemAddr), 64'(exp_q[0][AW+N-1:N]));
            check("wd", 64'(bus.MemWD), 64'(exp_q[0][N-1:0]));
            check("done_in_write", 64'(bus.DoneM), 64'd0);
        end else if (m_busy) begin
            check("we_in_done", 64'(bus.MemWE), 64'd0);
            check("done", 64'(bus.DoneM), 64'd1);
        end else begin
            check("we_idle", 64'(bus.MemWE), 64'd0);
            check("done_idle", 64'(bus.DoneM), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [6*N-1:0] rand_vec();
        logic [6*N-1:0] v;
        for (int i = 0; i < 6; i++) v[i*N +: N] = N'($urandom);
        return v;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_log.delete();
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic do_start(input bit scalar, input logic [6*N-1:0] data,
                            input logic [AW-1:0] base, input logic [5:0] mask,
                            output int sc);
        @(negedge clk);
        bus.StartM    = 1'b1;
        bus.ScalarM   = scalar;
        bus.VecDataM  = data;
        bus.BaseAddrM = base;
`ifdef VSTORE_MASK_EN
        bus.LaneMaskM = mask;
`else
        if (MASK_EN && mask == 6'd0) $display("note: mask ignored in this build");
`endif
        sc = cyc;
        @(negedge clk);
        bus.StartM    = 1'b0;
        bus.ScalarM   = 1'($urandom);
        bus.VecDataM  = rand_vec();
        bus.BaseAddrM = AW'($urandom);
`ifdef VSTORE_MASK_EN
        bus.LaneMaskM = 6'($urandom);
`endif
    endtask

    // Wait until the model reports idle; noisy mode also toggles StartM,
    // request inputs and MemReady while the store is in flight.
    task automatic wait_idle(input int limit, input bit noisy);
        int k;
        k = 0;
        while (m_busy && k < limit) begin
            if (noisy) begin
                bus.StartM    = ($urandom_range(0, 3) == 0);
                bus.BaseAddrM = AW'($urandom);
                bus.VecDataM  = rand_vec();
                bus.MemReady  = ($urandom_range(0, 3) != 0);
            end else begin
                bus.StartM = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.StartM = 1'b0;
        n_checks++;
        if (m_busy) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc;
        int nd;
        logic [6*N-1:0] v;

        bus.StartM    = 1'b0;
        bus.ScalarM   = 1'b0;
        bus.VecDataM  = '0;
        bus.BaseAddrM = '0;
        bus.MemReady  = 1'b1;
`ifdef VSTORE_MASK_EN
        bus.LaneMaskM = 6'd0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we", 64'(bus.MemWE), 64'd0);
        check("rst_addr", 64'(bus.MemAddr), 64'd0);
        check("rst_wd", 64'(bus.MemWD), 64'd0);
        check("rst_busy", 64'(bus.BusyM), 64'd0);
        check("rst_done", 64'(bus.DoneM), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full vector, lanes 0x11..0x66 at base 0x100
        clear_obs();
        v = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        do_start(1'b0, v, 32'h100, 6'h3F, sc);
        wait_idle(20, 1'b0);
        check("full_count", 64'(obs_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            check("full_addr", 64'(obs_addr[i]), 64'(32'h100 + i));
            check("full_data", 64'(obs_data[i]), 64'(8'h11 * (i + 1)));
            check("full_cyc", 64'(obs_cyc[i]), 64'(sc + 1 + i));
        end
        check("full_done_n", 64'(done_log.size()), 64'd1);
        if (done_log.size() > 0) check("full_done_cyc", 64'(done_log[0]), 64'(sc + 7));

        // Scalar store
        clear_obs();
        v = {8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'hA5};
        do_start(1'b1, v, 32'h20, 6'h3F, sc);
        wait_idle(20, 1'b0);
        check("scalar_count", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() > 0) begin
            check("scalar_addr", 64'(obs_addr[0]), 64'h20);
            check("scalar_data", 64'(obs_data[0]), 64'hA5);
            check("scalar_cyc", 64'(obs_cyc[0]), 64'(sc + 1));
        end
        if (done_log.size() > 0) check("scalar_done_cyc", 64'(done_log[0]), 64'(sc + 2));
        else check("scalar_done_n", 64'(done_log.size()), 64'd1);

        // Backpressure on lane 1 plus address wrap
        clear_obs();
        v = {8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1};
        do_start(1'b0, v, 32'hFFFF_FFFE, 6'h3F, sc);
        @(negedge clk);
        bus.MemReady = 1'b0;
        @(negedge clk);
        bus.MemReady = 1'b0;
        @(negedge clk);
        bus.MemReady = 1'b1;
        wait_idle(20, 1'b0);
        check("bp_count", 64'(obs_addr.size()), 64'd6);
        if (obs_addr.size() == 6) begin
            check("bp_lane1_addr", 64'(obs_addr[1]), 64'hFFFF_FFFF);
            check("bp_lane1_cyc", 64'(obs_cyc[1]), 64'(sc + 4));
            check("bp_wrap_addr", 64'(obs_addr[2]), 64'h0);
            check("bp_wrap_data", 64'(obs_data[2]), 64'hF3);
        end
        if (done_log.size() > 0) check("bp_done_cyc", 64'(done_log[0]), 64'(sc + 9));
        else check("bp_done_n", 64'(done_log.size()), 64'd1);

`ifdef VSTORE_MASK_EN
        // Sparse mask 6'b100101 at base 0x40
        clear_obs();
        v = rand_vec();
        do_start(1'b0, v, 32'h40, 6'b100101, sc);
        wait_idle(20, 1'b0);
        check("mask_count", 64'(obs_addr.size()), 64'd3);
        if (obs_addr.size() == 3) begin
            check("mask_a0", 64'(obs_addr[0]), 64'h40);
            check("mask_a1", 64'(obs_addr[1]), 64'h42);
            check("mask_a2", 64'(obs_addr[2]), 64'h45);
            check("mask_d2", 64'(obs_data[2]), 64'(v[5*N +: N]));
            check("mask_c2", 64'(obs_cyc[2]), 64'(sc + 3));
        end
        if (done_log.size() > 0) check("mask_done_cyc", 64'(done_log[0]), 64'(sc + 4));
        else check("mask_done_n", 64'(done_log.size()), 64'd1);

        // Empty mask
        clear_obs();
        do_start(1'b0, rand_vec(), 32'h80, 6'b000000, sc);
        wait_idle(20, 1'b0);
        check("empty_count", 64'(obs_addr.size()), 64'd0);
        if (done_log.size() > 0) check("empty_done_cyc", 64'(done_log[0]), 64'(sc + 1));
        else check("empty_done_n", 64'(done_log.size()), 64'd1);
`endif

        // Reset during the lane-3 write
        clear_obs();
        do_start(1'b0, rand_vec(), 32'h300, 6'h3F, sc);
        repeat (3) @(negedge clk);
        check("pre_rst_addr", 64'(bus.MemAddr), 64'h303);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_we", 64'(bus.MemWE), 64'd0);
        check("mid_rst_addr", 64'(bus.MemAddr), 64'd0);
        check("mid_rst_wd", 64'(bus.MemWD), 64'd0);
        check("mid_rst_busy", 64'(bus.BusyM), 64'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", 64'(done_log.size()), 64'd0);
        clear_obs();
        v = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        do_start(1'b0, v, 32'h500, 6'h3F, sc);
        wait_idle(20, 1'b0);
        check("post_rst_count", 64'(obs_addr.size()), 64'd6);
        if (obs_addr.size() > 0) check("post_rst_first", 64'(obs_addr[0]), 64'h500);

        // StartM pulses during WRITE and during DONE are ignored
        clear_obs();
        do_start(1'b0, rand_vec(), 32'h700, 6'h3F, sc);
        bus.StartM = 1'b1;
        bus.BaseAddrM = 32'h900;
        @(negedge clk);
        bus.StartM = 1'b0;
        while (cyc < sc + 7) @(negedge clk);
        bus.StartM = 1'b1;
        @(negedge clk);
        bus.StartM = 1'b0;
        repeat (4) @(negedge clk);
        check("ign_count", 64'(obs_addr.size()), 64'd6);
        check("ign_done_n", 64'(done_log.size()), 64'd1);
        check("ign_idle", 64'(bus.BusyM), 64'd0);

        // Randomized stores with noisy inputs and random backpressure
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] b;
            b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - AW'($urandom_range(0, 5)))
                                           : AW'($urandom);
            bus.MemReady = 1'b1;
            do_start(($urandom_range(0, 3) == 0), rand_vec(), b, 6'($urandom), sc);
            wait_idle(300, 1'b1);
            bus.MemReady = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
